// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are latched on grant, the ALU is evaluated for one cycle, and the result is held until accepted.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [SELW-1:0]  req0_sel,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [SELW-1:0]  req1_sel,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_z,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_z,
    output logic             busy,
    output logic             gnt_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [SELW-1:0]  sel;
    } op_t;

    op_t        req_op [2];
    op_t        op_q, op_d;
    logic [1:0] state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       gnt_q, gnt_d;
    logic [WIDTH-1:0] res_q;
    logic       z_q;
    logic       win;
    logic       grant;

    assign req_op[0] = '{op1: req0_op1, op2: req0_op2, sel: req0_sel};
    assign req_op[1] = '{op1: req1_op1, op2: req1_op2, sel: req1_sel};

    // A lone requester always wins; the pointer only breaks ties.
    assign win   = (&req_valid) ? rr_ptr_q : req_valid[1];
    assign grant = (state_q == S_IDLE) && (|req_valid);

    // Gated by rst_n so nothing is accepted while reset is held.
    assign req_ready[0] = rst_n && grant && !win;
    assign req_ready[1] = rst_n && grant && win;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d  = S_EXEC;
                    gnt_d    = win;
                    rr_ptr_d = ~win;
                    op_d     = req_op[win];
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            gnt_q    <= 1'b0;
            op_q     <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            if (state_q == S_EXEC) begin
                res_q <= alu_res;
                z_q   <= alu_z;
            end
        end
    end

    // The ALU always sees the latched operands, never the live request buses.
    assign alu_op1 = op_q.op1;
    assign alu_op2 = op_q.op2;
    assign alu_sel = op_q.sel;

    assign rsp_valid[0] = (state_q == S_RESP) && !gnt_q;
    assign rsp_valid[1] = (state_q == S_RESP) && gnt_q;
    assign rsp_res      = res_q;
    assign rsp_z        = z_q;
    assign busy         = (state_q != S_IDLE);
    assign gnt_id       = gnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model with a stub ALU.
module tb_alu_arbiter;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [S-1:0] req0_sel, req1_sel;
    logic [W-1:0] rsp_res, alu_op1, alu_op2, alu_res;
    logic [S-1:0] alu_sel;
    logic         rsp_z, alu_z, busy, gnt_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .SELW(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_z(rsp_z),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_z(alu_z),
        .busy(busy), .gnt_id(gnt_id)
    );

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [S-1:0] s);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        alu_res = ref_alu(alu_op1, alu_op2, alu_sel);
        alu_z   = (alu_res == '0);
    end

    // Transaction model: one operation in flight, aged in cycles since acceptance.
    bit           m_busy;
    int           m_age;
    bit           m_own, m_ptr;
    logic [W-1:0] m_op1, m_op2, m_res;
    logic [S-1:0] m_sel;
    bit           m_z;
    bit [1:0]     m_acc;

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_own = 0; m_ptr = 0;
        m_op1 = '0; m_op2 = '0; m_sel = '0; m_res = '0; m_z = 0; m_acc = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit pick();
        if (req_valid == 2'b11) return m_ptr;
        return req_valid[1];
    endfunction

    task automatic compare();
        logic [1:0] e_rr, e_rv;
        e_rr = (rst_n && !m_busy && req_valid != 2'b00) ? (pick() ? 2'b10 : 2'b01) : 2'b00;
        e_rv = (m_busy && m_age == 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 64'(req_ready), 64'(e_rr));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("gnt_id", 64'(gnt_id), 64'(m_own));
        chk("rsp_res", 64'(rsp_res), 64'(m_res));
        chk("rsp_z", 64'(rsp_z), 64'(m_z));
        chk("alu_op1", 64'(alu_op1), 64'(m_op1));
        chk("alu_op2", 64'(alu_op2), 64'(m_op2));
        chk("alu_sel", 64'(alu_sel), 64'(m_sel));
    endtask

    task automatic model_update();
        bit w;
        m_acc = '0;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_age = 2;
                m_res = ref_alu(m_op1, m_op2, m_sel);
                m_z   = (m_res == '0);
            end else if (rsp_ready[m_own]) begin
                m_busy = 0;
            end
        end else if (req_valid != 2'b00) begin
            w = pick();
            m_acc[w] = 1'b1;
            m_busy = 1; m_age = 1; m_own = w; m_ptr = ~w;
            m_op1 = w ? req1_op1 : req0_op1;
            m_op2 = w ? req1_op2 : req0_op2;
            m_sel = w ? req1_sel : req0_sel;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        compare();
        model_update();
        @(negedge clk);
    endtask

    task automatic set0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [S-1:0] s);
        req0_op1 = a; req0_op2 = b; req0_sel = s;
    endtask

    task automatic set1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [S-1:0] s);
        req1_op1 = a; req1_op2 = b; req1_sel = s;
    endtask

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(3) == 0) return W'($urandom_range(3));
        return W'($urandom);
    endfunction

    initial begin
        int k, budget;
        logic [W-1:0] held;
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        set0(1, 2, 0); set1(3, 4, 0);
        model_reset();
        @(negedge clk);
        settle();
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        step();
        req_valid = 2'b00; rst_n = 1'b1;
        settle(); step();

        // Single request: 10 + 15.
        req_valid = 2'b01; set0(10, 15, 0); rsp_ready = 2'b11;
        settle();
        chk("single_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 2'b00; settle(); step();
        settle();
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_res", 64'(rsp_res), 64'd25);
        chk("single_rsp_z", 64'(rsp_z), 64'd0);
        step();

        // Zero flag on requester 1: 15 - 15.
        req_valid = 2'b10; set1(15, 15, 1);
        settle(); step();
        req_valid = 2'b00; settle(); step();
        settle();
        chk("zero_rsp_valid", 64'(rsp_valid), 64'd2);
        chk("zero_rsp_res", 64'(rsp_res), 64'd0);
        chk("zero_rsp_z", 64'(rsp_z), 64'd1);
        chk("zero_gnt_id", 64'(gnt_id), 64'd1);
        step();

        // Back-pressure: response held while req1 waits.
        req_valid = 2'b01; set0(7, 3, 1); rsp_ready = 2'b00;
        settle(); step();
        req_valid = 2'b10; set1(5, 6, 0);
        settle(); step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_res", 64'(rsp_res), 64'd4);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 2'b01;
        settle(); step();
        rsp_ready = 2'b00;
        settle();
        chk("bp_req1_granted", 64'(req_ready), 64'd2);
        step();
        req_valid = 2'b00;

        // Reset while requester 1's operation is in EXEC.
        settle();
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0; model_reset();
        settle();
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rsp_res", 64'(rsp_res), 64'd0);
        chk("mid_alu_op1", 64'(alu_op1), 64'd0);
        chk("mid_alu_op2", 64'(alu_op2), 64'd0);
        step();
        rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        set0(100, 1, 1); set1(200, 2, 0);
        settle();
        chk("post_reset_first_grant", 64'(req_ready), 64'd1);

        // Contention: both held valid, grants must alternate from 0.
        k = 0; budget = 0;
        while (k < 8 && budget < 60) begin
            if (budget > 0) settle();
            if (req_ready != 2'b00) begin
                chk("contention_order", 64'(req_ready[1]), 64'(k % 2));
                k++;
            end
            step();
            budget++;
        end
        chk("contention_count", 64'(k), 64'd8);
        req_valid = 2'b00; settle(); step();

        // Randomized traffic with occasional mid-flight resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || m_acc[i]) begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    held = rnd_op();
                    if (i == 0) set0(held, ($urandom_range(3) == 0) ? held : rnd_op(), S'($urandom_range(4)));
                    else        set1(held, ($urandom_range(3) == 0) ? held : rnd_op(), S'($urandom_range(4)));
                end
            end
            rsp_ready = 2'($urandom_range(3));
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(250) == 0) begin
                rst_n = 1'b0; model_reset();
            end
            settle();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, such as the execute stage and an address/branch unit. Each requester has a valid/ready request channel and a valid/ready response channel. The block grants the ALU round-robin, registers the operands, drives the ALU for one cycle, and registers the result and zero flag. It then holds the response until the winning requester accepts it.

## Interface
- `WIDTH`, 32, operand/result width (matches ALU OP1/OP2/Res)
- `SELW`, 4, operation-select width (matches ALU ALUSel)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  bit i: requester i presents an operation
- `req_ready`  out  2  bit i: operation i accepted this cycle
- `req0_op1`, `req0_op2`  in  WIDTH  requester 0 operands
- `req0_sel`  in  SELW  requester 0 operation select
- `req1_op1`, `req1_op2`  in  WIDTH  requester 1 operands
- `req1_sel`  in  SELW  requester 1 operation select
- `rsp_valid`  out  2  bit i: result for requester i available
- `rsp_ready`  in  2  bit i: requester i takes result
- `rsp_res`  out  WIDTH  registered ALU result (shared by both requesters)
- `rsp_z`  out  1  registered ALU zero flag
- `alu_op1`, `alu_op2`  out  WIDTH  to ALU OP1/OP2
- `alu_sel`  out  SELW  to ALU ALUSel
- `alu_res`  in  WIDTH  from ALU Res
- `alu_z`  in  1  from ALU Z
- `busy`  out  1  state is not IDLE
- `gnt_id`  out  1  requester owning the current operation

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
- **Priority pointer `rr_ptr`** (reset 0): names the requester that wins a tie.
- **Grant in IDLE**:
  - If exactly one `req_valid` bit is set, that requester wins.
  - If both are set, requester `rr_ptr` wins.
  - `req_ready[g]` = 1 combinationally, for the winner only. It is allowed to depend on `req_valid`.
  - The loser's `req_ready` stays 0; it must hold its request stable.
- **IDLE -> EXEC** on any valid request:
  - Latch op1, op2 and sel of winner g into internal registers.
  - `gnt_id <= g`, `rr_ptr <= ~g`.
- **EXEC**:
  - `alu_op1`/`alu_op2`/`alu_sel` are driven from the latched registers.
  - At the clock edge, capture `rsp_res <= alu_res` and `rsp_z <= alu_z`.
  - Move to RESP unconditionally.
- **RESP**:
  - `rsp_valid[gnt_id]` = 1; the other bit is 0.
  - `rsp_res`/`rsp_z` are held stable.
  - When `rsp_ready[gnt_id]` = 1, move to IDLE. Otherwise stay, with the response held indefinitely.
  - `rsp_ready` of the non-granted requester is ignored.
- **ALU drive outside EXEC**:
  - The ALU is driven from the same latched registers in all states, so it never sees a mid-operation change.
  - Latched registers are zero after reset.
- **Requests outside IDLE**: no new request is accepted in EXEC or RESP; `req_ready` = 0 there.
- **Width rules**: the block passes data through and does no arithmetic. `rsp_res` is exactly WIDTH bits, as returned by the ALU.

## Timing
- **Reset values**:
  - `req_ready` = 0 while in reset, `rsp_valid` = 0, `rsp_res` = 0, `rsp_z` = 0.
  - `alu_op1` = `alu_op2` = 0, `alu_sel` = 0.
  - `busy` = 0, `gnt_id` = 0, `rr_ptr` = 0.
- **Latency**: request accepted in cycle N -> EXEC in N+1 -> `rsp_valid` high in N+2.
- **Throughput**: best case is one operation per 3 cycles, with `rsp_ready` held high. A new grant is possible in the cycle after the RESP handshake.
- **Simultaneous events**:
  - Both requests valid: `rr_ptr` wins, and the other requester wins the next grant if it is still valid.
  - A single persistent requester is granted back-to-back; the pointer does not block it.
- **Reset mid-operation** (`rst_n` low in EXEC or RESP):
  - Immediate asynchronous return to IDLE with all outputs at their reset values.
  - The in-flight operation is dropped and no response is issued.
- `busy` = 1 exactly in EXEC and RESP. `gnt_id` changes only on a grant.

## Test plan
Benches use a stub ALU: sel 0 -> op1+op2, sel 1 -> op1−op2, Z = (Res==0).
- **Single request**: req0 op1=10, op2=15, sel=0, `rsp_ready` high -> `req_ready`=2'b01 in N, `rsp_valid`=2'b01 in N+2, `rsp_res`=25, `rsp_z`=0.
- **Zero flag**: req1 op1=15, op2=15, sel=1 -> `rsp_valid`=2'b10, `rsp_res`=0, `rsp_z`=1, `gnt_id`=1.
- **Contention**: both requests valid from reset and held, each re-presented after its response -> grant order 0,1,0,1; `rr_ptr` alternates; no starvation over 8 operations.
- **Back-pressure**: `rsp_ready` low for 5 cycles in RESP, with req1 valid meanwhile -> response held stable, `req_ready`=0, and req1 is granted only after the handshake.
- **Reset mid-operation**: assert `rst_n`=0 in EXEC -> `busy`, `rsp_valid`, `rsp_res` and the ALU drive return to 0 immediately; after release, the first grant goes to requester 0.
